// File: rtl/mult_div_unit_if.sv
// Issue/readback bus between the E stage and the multiply/divide unit.
// Optional MDU_CANCEL_EN adds the flush-driven cancel strobe.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hi;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  modport master (
    output start, op, a, b, rd_hi,
`ifdef MDU_CANCEL_EN
    output cancel,
`endif
    input  rdata, busy, done
  );

  modport slave (
    input  start, op, a, b, rd_hi,
`ifdef MDU_CANCEL_EN
    input  cancel,
`endif
    output rdata, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: fixed-latency mult/div plus MTHI/MTLO.
// Define MDU_CANCEL_EN to add a cancel input that aborts an in-flight op.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        busy_q, done_q;

  logic [63:0] prod_d;
  logic [31:0] mag_a, mag_b, divisor, q_mag, r_mag;
  logic [31:0] res_hi_d, res_lo_d;
  logic        is_signed, div_zero;

  // Result is computed from the latched operands and only consumed at commit.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    prod_d    = '0;
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    div_zero  = (b_q == 32'd0);
    mag_a     = (is_signed && a_q[31]) ? -a_q : a_q;
    mag_b     = (is_signed && b_q[31]) ? -b_q : b_q;
    divisor   = div_zero ? 32'd1 : mag_b;
    q_mag     = mag_a / divisor;
    r_mag     = mag_a % divisor;
    res_hi_d  = (is_signed && a_q[31]) ? -r_mag : r_mag;
    res_lo_d  = (is_signed && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
    if (op_q == OP_MULT) begin
      prod_d = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
    end else begin
      prod_d = {32'd0, a_q} * {32'd0, b_q};
    end
    if ((op_q == OP_MULT) || (op_q == OP_MULTU)) begin
      res_hi_d = prod_d[63:32];
      res_lo_d = prod_d[31:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
`ifdef MDU_CANCEL_EN
      if (bus.cancel) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
`else
      begin
`endif
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              case (bus.op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                  op_q    <= bus.op;
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  cnt_q   <= (bus.op == OP_MULT || bus.op == OP_MULTU) ? MULT_N : DIV_N;
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                end
                OP_MTHI: hi_q <= bus.a;
                OP_MTLO: lo_q <= bus.a;
                default: ;
              endcase
            end
          end
          RUN: begin
            // Commit on the edge where the counter reaches zero.
            if (cnt_q == 5'd1) begin
              if ((op_q == OP_MULT) || (op_q == OP_MULTU) || !div_zero) begin
                hi_q <= res_hi_d;
                lo_q <= res_lo_d;
              end
              cnt_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.rdata = bus.rd_hi ? hi_q : lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed plan cases plus random traffic
// checked against an arithmetic reference model.
module tb_mult_div_unit;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  logic cancel_req;
  always #5 clk = ~clk;

  mult_div_unit_if bus ();
`ifdef MDU_CANCEL_EN
  assign bus.cancel = cancel_req;
`endif

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi, m_lo;
  exp_t        pend;
  int          busy_left;
  bit          m_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic read_reg(input bit hi, output logic [31:0] v);
    bus.rd_hi = hi;
    #1;
    v = bus.rdata;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] v;
    read_reg(1'b1, v);
    check({tag, "_hi"}, v, hi);
    read_reg(1'b0, v);
    check({tag, "_lo"}, v, lo);
  endtask

  // Reference semantics straight from the arithmetic rules.
  function automatic exp_t ref_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
    exp_t        e;
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    e.hi = m_hi;
    e.lo = m_lo;
    e.lat = (o <= 3'd2) ? MULT_N : DIV_N;
    sa = aa;
    sb = bb;
    case (o)
      3'd1: begin
        ps   = longint'(sa) * longint'(sb);
        e.hi = ps[63:32];
        e.lo = ps[31:0];
      end
      3'd2: begin
        pu   = {32'd0, aa} * {32'd0, bb};
        e.hi = pu[63:32];
        e.lo = pu[31:0];
      end
      3'd3: if (bb != 0) begin
        if (aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = 32'h0;
        end else begin
          e.lo = sa / sb;
          e.hi = sa % sb;
        end
      end
      default: if (bb != 0) begin
        e.lo = aa / bb;
        e.hi = aa % bb;
      end
    endcase
    return e;
  endfunction

  // One clock of stimulus; the model advances at the edge, then outputs are checked.
  task automatic cyc(input bit s, input logic [2:0] o, input logic [31:0] aa,
                     input logic [31:0] bb, input bit c);
    bus.start  = s;
    bus.op     = o;
    bus.a      = aa;
    bus.b      = bb;
    cancel_req = c;
    @(posedge clk);
    m_done = 1'b0;
    if (c) begin
      busy_left = 0;
      sb_q.delete();
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        m_hi   = pend.hi;
        m_lo   = pend.lo;
        m_done = 1'b1;
      end
    end else if (s) begin
      if (o >= 3'd1 && o <= 3'd4) begin
        pend = ref_op(o, aa, bb);
        sb_q.push_back(pend);
        busy_left = pend.lat;
      end else if (o == 3'd5) begin
        m_hi = aa;
      end else if (o == 3'd6) begin
        m_lo = aa;
      end
    end
    #1;
    bus.start  = 1'b0;
    cancel_req = 1'b0;
    check("busy", 32'(bus.busy), 32'(busy_left > 0));
    check("done", 32'(bus.done), 32'(m_done));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_left > 0 || sb_q.size() > 0) && n < 200) begin
      cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL idle_timeout: got %0d cycles want <200", n);
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: on every done pulse pop the scoreboard and compare latency and HI/LO.
  initial begin
    int          run;
    exp_t        e;
    logic [31:0] v;
    run = 0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want done=0 at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("busy_len", 32'(run), 32'(e.lat));
          read_reg(1'b1, v);
          check("sb_hi", v, e.hi);
          read_reg(1'b0, v);
          check("sb_lo", v, e.lo);
        end
        run = 0;
      end else if (bus.busy === 1'b1) begin
        run++;
      end else begin
        run = 0;
      end
    end
  end

  initial begin
    logic [31:0] aa, bb;
    bit          s, c;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.a      = '0;
    bus.b      = '0;
    bus.rd_hi  = 1'b0;
    cancel_req = 1'b0;
    m_hi = '0; m_lo = '0; busy_left = 0; m_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check_hilo("rst", 32'h0, 32'h0);

    cyc(1'b1, 3'd5, 32'h1234_5678, 32'h0, 1'b0);
    cyc(1'b1, 3'd6, 32'h9ABC_DEF0, 32'h0, 1'b0);
    check_hilo("mt", 32'h1234_5678, 32'h9ABC_DEF0);

    cyc(1'b1, 3'd1, 32'hFFFF_FFFE, 32'h3, 1'b0);
    wait_idle();
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    cyc(1'b1, 3'd2, 32'hFFFF_FFFE, 32'h3, 1'b0);
    wait_idle();
    check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    cyc(1'b1, 3'd3, 32'hFFFF_FFF9, 32'h2, 1'b0);
    wait_idle();
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    cyc(1'b1, 3'd4, 32'h7, 32'h2, 1'b0);
    wait_idle();
    check_hilo("divu", 32'h1, 32'h3);
    cyc(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    check_hilo("div_ovf", 32'h0, 32'h8000_0000);

    cyc(1'b1, 3'd5, 32'hAAAA, 32'h0, 1'b0);
    cyc(1'b1, 3'd6, 32'h5555, 32'h0, 1'b0);
    cyc(1'b1, 3'd4, 32'h1234, 32'h0, 1'b0);
    wait_idle();
    check_hilo("div0", 32'hAAAA, 32'h5555);

    // MTLO during busy is dropped; a MULT issued in the done cycle is taken.
    cyc(1'b1, 3'd1, 32'h7, 32'h6, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 3'd6, 32'hDEAD, 32'h0, 1'b0);
    while (busy_left > 0) cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    check_hilo("mult_ign", 32'h0, 32'd42);
    cyc(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    check_hilo("b2b", 32'h0, 32'h1);

    // Async reset in the middle of a divide.
    cyc(1'b1, 3'd4, 32'd100, 32'd7, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0; busy_left = 0;
    sb_q.delete();
    check("arst_busy", 32'(bus.busy), 32'd0);
    check_hilo("arst", 32'h0, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

`ifdef MDU_CANCEL_EN
    cyc(1'b1, 3'd5, 32'h0F0F, 32'h0, 1'b0);
    cyc(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 3'd6, 32'hBEEF, 32'h0, 1'b1);
    repeat (DIV_N) cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    check_hilo("cancel", 32'h0F0F, 32'h0);
`endif

    for (int i = 0; i < 600; i++) begin
      s  = ($urandom_range(0, 2) == 0);
      aa = rand_word();
      bb = rand_word();
`ifdef MDU_CANCEL_EN
      c = ($urandom_range(0, 40) == 0);
`else
      c = 1'b0;
`endif
      cyc(s, 3'($urandom_range(0, 7)), aa, bb, c);
    end
    wait_idle();
    check_hilo("final", m_hi, m_lo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide responder for the pipelined MIPS datapath.
- The E stage issues a one-cycle start with an opcode and two operands.
- The unit holds busy for a fixed latency, then commits the HI/LO registers.
- The hazard logic uses busy and start to stall later HI/LO instructions; mfhi/mflo read HI/LO through a combinational port.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (legal range 1-31)
- DIV_CYCLES, 10, cycles busy stays high for div/divu (legal range 1-31)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  one-cycle issue strobe from E stage
- op  input  3  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; 0 and 7 are no-ops
- a  input  32  operand rs (dividend / multiplicand / MTHI-MTLO data)
- b  input  32  operand rt (divisor / multiplier)
- rd_hi  input  1  read select: 1=HI, 0=LO
- rdata  output  32  combinational: HI if rd_hi else LO
- busy  output  1  high while a mult/div is in flight
- done  output  1  one-cycle pulse after HI/LO commit of a mult/div

Behaviour:
- Reset (async): HI=0, LO=0, busy=0, done=0, cycle counter=0, state=IDLE. Reset asserted mid-operation aborts the operation; no HI/LO commit occurs.
- States:
  - IDLE: accepts start.
  - RUN: counter counts down; start is ignored.
- Issue in IDLE, start=1, op in 1..4, sampled at edge t0:
  - latch a, b and op internally;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN, busy=1 after t0.
  - a and b may change after t0 without effect.
- RUN: counter decrements each edge. At the edge where the counter reaches 0 (edge t0+N), the unit commits HI/LO, sets busy=0, sets done=1 for exactly one cycle, and returns to IDLE.
- Busy waveform: busy is high for exactly N cycles, from the edge after issue until the edge after the commit.
- Issue in IDLE, start=1, op 5/6: HI (or LO) is loaded from a at that edge. busy stays 0 and no done pulse occurs.
- start=1 in RUN: ignored entirely, including MTHI/MTLO. The pipeline must stall; this is a caller contract, and the verifier checks that the operation is dropped.
- start=1 with op 0 or 7: no state change.
- Back-to-back issue: a new start on the same cycle that done=1 is accepted, because the unit is in IDLE then.
- MULT: signed 64-bit product of a and b; HI=product[63:32], LO=product[31:0].
- MULTU: the same with unsigned operands.
- DIV: signed division. LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
- DIVU: unsigned division; LO = quotient, HI = remainder.
- Divide by zero (b=0 latched): the full DIV_CYCLES latency is still taken and done still pulses, but HI and LO are unchanged.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- rdata reflects HI/LO combinationally. It shows the old value while busy and the new value in the done cycle.
- The internal algorithm is free (iterative or registered combinational); only the result and timing above are binding.

Optional Feature:
- Macro: MDU_CANCEL_EN
- With the macro defined:
  - adds input `cancel` (1 bit); on a posedge with cancel=1, any in-flight op is aborted. State returns to IDLE, busy=0, no done pulse, HI/LO unchanged.
  - cancel has priority over start in the same cycle, so start is also dropped; this covers the exception/flush path.
- Without the macro: no cancel port; an operation always runs to completion unless reset is asserted.

Test Plan:
- Reset, then MTHI a=0x12345678 and next cycle MTLO a=0x9ABCDEF0 -> busy stays 0; rdata(rd_hi=1)=0x12345678, rdata(rd_hi=0)=0x9ABCDEF0.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> busy high 5 cycles, done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU with b=0 preceded by HI=0xAAAA, LO=0x5555 -> busy 10 cycles, done pulses, HI/LO unchanged.
- Issue MULT, then assert start with MTLO at cycle 2 of busy -> MTLO ignored, LO = product. A new MULT issued in the done cycle is accepted and busy rises the next cycle.
- Assert reset at cycle 3 of a DIV -> busy=0 and HI=LO=0 immediately (async). With MDU_CANCEL_EN, cancel at cycle 3 -> busy=0 next edge, no done, HI/LO unchanged.
